data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 14 +
 rtl/data_mem_array.sv | 45 ++++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared FSM encoding and constants for the data memory responder
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
    localparam int          LANE_W            = 8;
    localparam int          NUM_LANES         = 4;

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - DEPTH x 32 synchronous RAM with byte write enables and registered read
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [NUM_LANES-1:0] i_be,
    input  logic [AW-1:0]        i_addr,
    input  logic [31:0]          i_wdata,
    input  logic                 i_clr,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // The read register doubles as the response data register, so stores and clears force it to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'd0;
        end else if (i_clr) begin
            r_rdata <= 32'd0;
        end else if (i_en) begin
            r_rdata <= i_we ? 32'd0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state load/store responder; DATA_MEM_RESPONDER_ERRCHK_EN enables address fault checking
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic        w_acc_we;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic [3:0]  w_acc_be;
    logic        w_access;
    logic        w_fault;
    logic        w_clr;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;
    logic        w_unused_bits;

    // With zero wait states the access happens on the accept edge, straight from the request inputs.
    assign w_acc_we    = (LATENCY == 0) ? req_we    : r_we;
    assign w_acc_addr  = (LATENCY == 0) ? req_addr  : r_addr;
    assign w_acc_wdata = (LATENCY == 0) ? req_wdata : r_wdata;
    assign w_acc_be    = (LATENCY == 0) ? req_be    : r_be;
    assign w_access    = reset && ((LATENCY == 0) ? (r_state == ST_IDLE && req_valid)
                                                  : (r_state == ST_WAIT && r_cnt == 4'd1));
    assign w_clr       = (r_state == ST_RESP) && r_rsp_valid && rsp_ready;

    assign w_off         = w_acc_addr - BASE_ADDR;
    assign w_idx         = w_off[AW+1:2];
    assign w_unused_bits = &{1'b0, w_off[31:AW+2], w_off[1:0]};

`ifdef DATA_MEM_RESPONDER_ERRCHK_EN
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    logic r_rsp_err;

    assign w_fault = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr < BASE_ADDR) ||
                     ({1'b0, w_acc_addr} >= END_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_err <= 1'b0;
        end else if (w_access) begin
            r_rsp_err <= w_fault;
        end else if (w_clr) begin
            r_rsp_err <= 1'b0;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_fault = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // RESP spends one cycle with rsp_valid still low; this is the bubble that makes latency LATENCY+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_cnt   <= 4'(LATENCY);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (w_access && !w_fault),
        .i_we    (w_acc_we),
        .i_be    (w_acc_be),
        .i_addr  (w_idx),
        .i_wdata (w_acc_wdata),
        .i_clr   (w_clr),
        .o_rdata (rsp_rdata)
    );

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - table-driven bench for data_mem_responder at LATENCY=2 and LATENCY=0
module tb_data_mem_responder;

`ifdef DATA_MEM_RESPONDER_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    typedef struct {
        int          dut;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h1001_0000), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h1001_0000), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input string tag, input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rd, input logic exp_err);
        int k;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_ready = 1'b1; req_valid[d] = 1'b1;
        k = 0;
        while (req_ready[d] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_accept"}, {31'd0, req_ready[d]}, 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (rsp_valid[d] !== 1'b1 && k < 20);
        chk({tag, "_lat"}, 32'(k - 1), 32'(lat_of(d) + 1));
        chk({tag, "_rdata"}, rsp_rdata[d], exp_rd);
        chk({tag, "_err"}, {31'd0, rsp_err[d]}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_vclr"}, {31'd0, rsp_valid[d]}, 32'd0);
        chk({tag, "_dclr"}, rsp_rdata[d], 32'd0);
        chk({tag, "_rdy"}, {31'd0, req_ready[d]}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        int acc [3];

        rst_n = 1'b0; req_valid = 2'b00; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_rdy", d), {31'd0, req_ready[d]}, 32'd1);
            chk($sformatf("rst%0d_vld", d), {31'd0, rsp_valid[d]}, 32'd0);
            chk($sformatf("rst%0d_rdata", d), rsp_rdata[d], 32'd0);
            chk($sformatf("rst%0d_err", d), {31'd0, rsp_err[d]}, 32'd0);
        end
        rst_n = 1'b1;

        vecs.push_back('{0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h1001_0004, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h1001_0004, 32'h0000_AB00, 4'h2, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h1001_0004, 32'h0,         4'hF, 32'hDEAD_ABEF, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h1001_0004, 32'h1122_3344, 4'h0, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'hDEAD_ABEF, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h1001_0000, 32'h5566_7788, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h1001_0008, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h1001_1000, 32'h99AA_BBCC, 4'hF, 32'h0, ERRCHK});
        vecs.push_back('{0, 1'b0, 32'h1001_0000, 32'h0, 4'hF,
                         ERRCHK ? 32'h5566_7788 : 32'h99AA_BBCC, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h1001_0002, 32'h0, 4'hF,
                         ERRCHK ? 32'h0 : 32'h99AA_BBCC, ERRCHK});
        vecs.push_back('{0, 1'b0, 32'h1001_0008, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1, 1'b1, 32'h1001_0010, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h1001_0010, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0});
        vecs.push_back('{1, 1'b1, 32'h1001_0010, 32'h0000_00EE, 4'h1, 32'h0, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h1001_0010, 32'h0,         4'hF, 32'h0BAD_F0EE, 1'b0});

        foreach (vecs[i]) begin
            run_txn($sformatf("v%0d", i), vecs[i].dut, vecs[i].we, vecs[i].addr,
                    vecs[i].wdata, vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Back-to-back loads on the zero-latency instance: one accept every 3 cycles.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h1001_0010; req_be = 4'hF; rsp_ready = 1'b1; req_valid[1] = 1'b1;
        n = 0; k = 0;
        while (n < 3 && k < 30) begin
            if (rsp_valid[1] === 1'b1) chk("b2b_rdata", rsp_rdata[1], 32'h0BAD_F0EE);
            if (req_ready[1] === 1'b1) begin
                acc[n] = cyc + 1;
                n++;
                if (n == 3) begin
                    @(posedge clk);
                    #1 req_valid[1] = 1'b0;
                end
            end
            @(negedge clk);
            k++;
        end
        chk("b2b_count", 32'(n), 32'd3);
        chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
        chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
        repeat (3) @(negedge clk);
        chk("b2b_idle", {31'd0, req_ready[1]}, 32'd1);

        // Backpressure: response held while a second request waits on req_valid.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h1001_0004; rsp_ready = 1'b0; req_valid[0] = 1'b1;
        k = 0;
        while (req_ready[0] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req_addr = 32'h1001_0008;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (rsp_valid[0] !== 1'b1 && k < 20);
        chk("bp_lat", 32'(k - 1), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_vld%0d", i), {31'd0, rsp_valid[0]}, 32'd1);
            chk($sformatf("bp_rdata%0d", i), rsp_rdata[0], 32'hDEAD_ABEF);
            chk($sformatf("bp_rdy%0d", i), {31'd0, req_ready[0]}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_vld", {31'd0, rsp_valid[0]}, 32'd0);
        chk("bp_hs_rdy", {31'd0, req_ready[0]}, 32'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (rsp_valid[0] !== 1'b1 && k < 20);
        chk("bp2_lat", 32'(k - 1), 32'd3);
        chk("bp2_rdata", rsp_rdata[0], 32'hCAFE_F00D);
        @(negedge clk);

        // Reset in WAIT discards the pending store.
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h1001_0008; req_wdata = 32'h1234_5678; req_be = 4'hF;
        req_valid[0] = 1'b1;
        k = 0;
        while (req_ready[0] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rw_in_wait", {31'd0, req_ready[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rw_rdy", {31'd0, req_ready[0]}, 32'd1);
        chk("rw_vld", {31'd0, rsp_valid[0]}, 32'd0);
        chk("rw_rdata", rsp_rdata[0], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn("rw_load", 0, 1'b0, 32'h1001_0008, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
